// File: rtl/axi4lite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4lite_pkg: shared FSM encodings and AXI4-Lite constants          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package axi4lite_pkg;

  localparam int STATE_W = $clog2(4);
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ADDR = 2'd1;
  localparam state_t S_DATA = 2'd2;
  localparam state_t S_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/axi4lite_read_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4lite_read_master: single-outstanding AXI4-Lite read initiator   |
// | Optional hang-recovery abort: define AXI4LITE_READ_TIMEOUT_EN       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module axi4lite_read_master
  import axi4lite_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [C_DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [C_ADDR_WIDTH-1:0] araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [C_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  state_t                    state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [C_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      timeout_hit;

`ifdef AXI4LITE_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(C_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  assign timeout_hit = (cnt_q == CNT_TERM);
  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
`ifdef AXI4LITE_READ_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
`ifdef AXI4LITE_READ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
`ifdef AXI4LITE_READ_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == S_ADDR || state_q == S_DATA) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          araddr_d = cmd_addr;
          state_d  = S_ADDR;
`ifdef AXI4LITE_READ_TIMEOUT_EN
          cnt_d         = '0;
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      S_ADDR, S_DATA: begin
        // A handshake on the terminal-count cycle takes priority over the abort
        if (state_q == S_ADDR && arready) begin
          state_d = S_DATA;
        end else if (state_q == S_DATA && rvalid) begin
          rsp_data_d = rdata;
          rsp_resp_d = rresp;
          state_d    = S_RESP;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_resp_d = RESP_DECERR;
          state_d    = S_RESP;
`ifdef AXI4LITE_READ_TIMEOUT_EN
          rsp_timeout_d = 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from registered state
  always_comb begin
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_ADDR:  arvalid   = 1'b1;
      S_DATA:  rready    = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign araddr   = araddr_q;
  assign arprot   = ARPROT_DEFAULT;
  assign rsp_data = rsp_data_q;
  assign rsp_resp = rsp_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_read_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi4lite_read_master: directed self-checking bench               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_axi4lite_read_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi4lite_read_master #(
    .C_ADDR_WIDTH    (32),
    .C_DATA_WIDTH    (32),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .araddr     (araddr),
    .arprot     (arprot),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current (idle) cycle and advance into S_ADDR
  task automatic issue(input logic [31:0] addr);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; rsp_ready = 1'b1;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_arvalid",   arvalid,   0);
    check("rst_rready",    rready,    0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_araddr",    araddr,    0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_rsp_resp",  rsp_resp,  0);
    check("rst_timeout",   rsp_timeout, 0);
    check("arprot",        arprot,    0);
    reset = 1'b0;
    tick();

    // Zero-wait slave: accept at cycle 0, arvalid 1, rready 2, rsp_valid 3, idle 4
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    issue(32'h0000_0010);
    check("zw_c1_arvalid", arvalid, 1);
    check("zw_c1_araddr",  araddr,  32'h10);
    check("zw_c1_rready",  rready,  0);
    check("zw_c1_cmd_rdy", cmd_ready, 0);
    tick();
    check("zw_c2_rready",  rready,  1);
    check("zw_c2_arvalid", arvalid, 0);
    tick();
    check("zw_c3_rsp_valid", rsp_valid, 1);
    check("zw_c3_rsp_data",  rsp_data,  32'hDEAD_BEEF);
    check("zw_c3_rsp_resp",  rsp_resp,  0);
    check("zw_c3_rready",    rready,    0);
    tick();
    check("zw_c4_cmd_ready", cmd_ready, 1);
    check("zw_c4_rsp_valid", rsp_valid, 0);

    // arready delayed: arvalid held 6 cycles with a stable address
    arready = 1'b0; rvalid = 1'b0;
    issue(32'h0000_0004);
    for (int k = 1; k <= 6; k++) begin
      check("dly_arvalid", arvalid, 1);
      check("dly_araddr",  araddr,  32'h4);
      check("dly_rready",  rready,  0);
      if (k == 6) arready = 1'b1;
      tick();
    end
    arready = 1'b0;
    check("dly_rready_after", rready, 1);
    check("dly_arvalid_drop", arvalid, 0);
    rvalid = 1'b1; rdata = 32'hCAFE_0004; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    check("dly_rsp_data", rsp_data, 32'hCAFE_0004);
    tick();
    check("dly_idle", cmd_ready, 1);

    // SLVERR passthrough with consumer back-pressure for 10 cycles
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10; rsp_ready = 1'b0;
    issue(32'h0000_0008);
    tick(); tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    for (int k = 0; k < 10; k++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h0000_0100;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data",  rsp_data,  32'h1234_5678);
      check("bp_rsp_resp",  rsp_resp,  2'b10);
      check("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_araddr_kept", araddr, 32'h8);
    rsp_ready = 1'b1;
    tick();
    check("bp_release_idle", cmd_ready, 1);
    check("bp_release_rspv", rsp_valid, 0);

    // Reset while in S_DATA, then a normal read
    arready = 1'b1; rvalid = 1'b0;
    issue(32'h0000_0040);
    tick();
    check("rs_in_data", rready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_arvalid",   arvalid,   0);
    check("rs_rready",    rready,    0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_cmd_ready", cmd_ready, 1);
    check("rs_araddr",    araddr,    0);
    rvalid = 1'b1; rdata = 32'hA5A5_5A5A; rresp = 2'b01;
    issue(32'h0000_0020);
    check("rs2_araddr", araddr, 32'h20);
    tick(); tick();
    check("rs2_rsp_valid", rsp_valid, 1);
    check("rs2_rsp_data",  rsp_data,  32'hA5A5_5A5A);
    check("rs2_rsp_resp",  rsp_resp,  2'b01);
    check("rs2_timeout",   rsp_timeout, 0);
    tick();
    check("rs2_idle", cmd_ready, 1);

`ifdef AXI4LITE_READ_TIMEOUT_EN
    // Slave never answers AR: abort after 16 cycles in S_ADDR
    arready = 1'b0; rvalid = 1'b0;
    issue(32'h0000_0030);
    for (int k = 1; k <= 16; k++) begin
      check("to_arvalid", arvalid, 1);
      check("to_rsp_valid_low", rsp_valid, 0);
      tick();
    end
    check("to_rsp_valid",  rsp_valid,   1);
    check("to_rsp_resp",   rsp_resp,    2'b11);
    check("to_rsp_data",   rsp_data,    0);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_arvalid_drop", arvalid,   0);
    tick();
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0077; rresp = 2'b00;
    issue(32'h0000_0034);
    check("to_clear_on_accept", rsp_timeout, 0);
    tick(); tick();
    check("to_next_data", rsp_data, 32'h77);
    tick();
`else
    check("no_timeout_tied", rsp_timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
